// File: rtl/dmem_responder.sv
// dmem_responder: multi-cycle word-addressed data memory for the MEM stage.
// Ports: clock/reset (async, active-high); mem_read/mem_write/addr/write_data
// request inputs; read_data registered load data; stall combinational hold;
// done one-cycle completion pulse; err error flag valid with done.
module dmem_responder #(
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] write_data,
  output logic [31:0] read_data,
  output logic        stall,
  output logic        done,
  output logic        err
);
  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, RESP = 2'd2} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
  logic rd_q, rd_d, wr_q, wr_d, err_q, err_d;
  logic [31:0] mem_q [DEPTH];
  logic req, commit, c_rd, c_wr, bad, do_wr;
  logic [31:0] c_addr, c_wdata;
  logic [ADDR_W-1:0] idx;
  // With LATENCY=1 the access commits on the accepting edge, so the live
  // inputs are used; otherwise the captured request is used.
  always_comb begin
    req     = mem_read | mem_write;
    c_addr  = state_q == IDLE ? addr : addr_q;
    c_wdata = state_q == IDLE ? write_data : wdata_q;
    c_rd    = state_q == IDLE ? mem_read : rd_q;
    c_wr    = state_q == IDLE ? mem_write : wr_q;
    commit  = (state_q == IDLE && req && LATENCY == 1) || (state_q == WAIT && cnt_q == 4'd0);
    bad     = ((c_addr >> ADDR_W) != '0) || (c_rd && c_wr);
    idx     = c_addr[ADDR_W-1:0];
    do_wr   = commit && c_wr && !bad;
    stall   = (state_q == IDLE && req) || state_q == WAIT;
    done    = state_q == RESP;
    err     = err_q;
    read_data = rdata_q;
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rd_d    = rd_q;
    wr_d    = wr_q;
    if (state_q == IDLE && req) begin
      addr_d  = addr;
      wdata_d = write_data;
      rd_d    = mem_read;
      wr_d    = mem_write;
      state_d = LATENCY == 1 ? RESP : WAIT;
      cnt_d   = LATENCY == 1 ? 4'd0 : 4'(LATENCY - 2);
    end else if (state_q == WAIT) begin
      state_d = cnt_q == 4'd0 ? RESP : WAIT;
      cnt_d   = cnt_q == 4'd0 ? 4'd0 : cnt_q - 4'd1;
    end else if (state_q == RESP) begin
      state_d = IDLE;
    end
    rdata_d = !commit ? rdata_q : bad ? 32'd0 : c_rd ? mem_q[idx] : rdata_q;
    err_d   = commit && bad;
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      wdata_q <= 32'd0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 32'd0;
    end else if (do_wr) begin
      mem_q[idx] <= c_wdata;
    end
  end
endmodule
